// File: rtl/hiscore_pkg.sv
// Shared state encodings, region entry type and constants for the hiscore upload path.
package hiscore_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PAUSE   = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_READY   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  typedef struct packed {
    logic [15:0] start;
    logic [7:0]  len_m1;
  } region_t;

  // The game CPU is held from PAUSE up to and including DONE.
  function automatic logic holds_pause(input logic [2:0] st);
    logic res;
    case (st)
      ST_PAUSE, ST_FETCH, ST_WAIT, ST_READY, ST_DONE: res = 1'b1;
      default:                                        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hiscore_dumper_region_table.sv
// Region table: decodes table downloads, stores {start, len-1} per entry, tracks the
// entry count and, with HS_DIRTY_REQ_EN defined, flags CPU writes landing in a region.
module hiscore_region_table
  import hiscore_pkg::*;
#(
  parameter int         AW        = 11,
  parameter int         ENTRIES   = 4,
  parameter logic [7:0] CFG_INDEX = 8'd3
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       idle,
  input  logic                       ioctl_download,
  input  logic                       ioctl_wr,
  input  logic [24:0]                ioctl_addr,
  input  logic [7:0]                 ioctl_dout,
  input  logic [7:0]                 ioctl_index,
  input  logic [$clog2(ENTRIES)-1:0] len_idx,
  input  logic [$clog2(ENTRIES)-1:0] start_idx,
  output logic [7:0]                 len_m1,
  output logic [AW-1:0]              start,
  output logic [$clog2(ENTRIES):0]   count,
  output logic                       configured,
  input  logic                       cpu_wr,
  input  logic [AW-1:0]              cpu_addr,
  output logic                       cpu_hit
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  region_t       tbl_q [ENTRIES];
  region_t       tbl_d [ENTRIES];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_base_s, k_next_s;
  logic          configured_q, configured_d;
  logic          dl_prev_q;
  logic          cfg_sel_s, dl_rise_s, dl_fall_s, wr_ok_s;
  logic [22:0]   k_s;
  logic [IW-1:0] k_idx_s;

  // Loading is only honoured while the dumper is idle, so a busy-time download is dropped whole.
  assign k_s          = ioctl_addr[24:2];
  assign k_idx_s      = k_s[IW-1:0];
  assign cfg_sel_s    = idle && (ioctl_index == CFG_INDEX);
  assign dl_rise_s    = cfg_sel_s && ioctl_download && !dl_prev_q;
  assign dl_fall_s    = cfg_sel_s && !ioctl_download && dl_prev_q;
  assign wr_ok_s      = cfg_sel_s && ioctl_download && ioctl_wr && (k_s < 23'(ENTRIES));
  assign count_base_s = dl_rise_s ? {CW{1'b0}} : count_q;
  assign k_next_s     = CW'(k_idx_s) + CW'(1'b1);

  // Next-state for table storage, entry count and the configured flag.
  always_comb begin
    tbl_d   = tbl_q;
    count_d = count_base_s;
    if (wr_ok_s) begin
      case (ioctl_addr[1:0])
        2'd0:    tbl_d[k_idx_s].start[15:8] = ioctl_dout;
        2'd1:    tbl_d[k_idx_s].start[7:0]  = ioctl_dout;
        2'd2:    tbl_d[k_idx_s].len_m1      = ioctl_dout;
        default: tbl_d[k_idx_s]             = tbl_q[k_idx_s];
      endcase
      if (k_next_s > count_base_s) count_d = k_next_s;
      else                         count_d = count_base_s;
    end else begin
      count_d = count_base_s;
    end
    if (dl_fall_s) configured_d = (count_q != {CW{1'b0}});
    else           configured_d = configured_q;
  end

  // Table state registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      count_q      <= {CW{1'b0}};
      configured_q <= 1'b0;
      dl_prev_q    <= 1'b0;
    end else begin
      tbl_q        <= tbl_d;
      count_q      <= count_d;
      configured_q <= configured_d;
      dl_prev_q    <= ioctl_download;
    end
  end

  assign len_m1     = tbl_q[len_idx].len_m1;
  assign start      = AW'(tbl_q[start_idx].start);
  assign count      = count_q;
  assign configured = configured_q;

`ifdef HS_DIRTY_REQ_EN
  logic [ENTRIES-1:0] hit_vec_s;

  // Distance from region start, modulo 2^AW, makes wrapping regions fall out naturally.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    logic [AW-1:0] rel_s;
    assign rel_s        = cpu_addr - AW'(tbl_q[g].start);
    assign hit_vec_s[g] = (CW'(g) < count_q) &&
                          ({8'd0, rel_s} <= {{AW{1'b0}}, tbl_q[g].len_m1});
  end

  assign cpu_hit = cpu_wr && (|hit_vec_s);
`else
  logic unused_cpu_s;
  assign unused_cpu_s = cpu_wr ^ (^cpu_addr);
  assign cpu_hit      = 1'b0;
`endif

endmodule

// File: rtl/hiscore_dumper.sv
// Hiscore upload responder: pauses the CPU and streams tabled RAM regions to the HPS.
// Optional macro HS_DIRTY_REQ_EN adds CPU-write dirty tracking driving ioctl_upload_req.
module hiscore_dumper
  import hiscore_pkg::*;
#(
  parameter int         AW         = 11,
  parameter int         ENTRIES    = 4,
  parameter logic [7:0] CFG_INDEX  = 8'd3,
  parameter logic [7:0] DATA_INDEX = 8'd4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_upload_req,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_dout,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  output logic          configured,
  output logic          busy
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ent_q, ent_d;
  logic [7:0]    off_q, off_d;
  logic          pend_q, pend_d;
  logic          up_prev_q;
  logic [7:0]    din_q, din_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          pause_q, pause_d;
  logic          busy_q, busy_d;

  logic [CW-1:0] count_s;
  logic          configured_s, hit_s, strobe_s;
  logic          up_rise_s, up_fall_s;
  logic [AW-1:0] nxt_start_s;
  logic [7:0]    cur_len_s;

  assign up_rise_s = ioctl_upload && !up_prev_q;
  assign up_fall_s = !ioctl_upload && up_prev_q;

  hiscore_region_table #(
    .AW        (AW),
    .ENTRIES   (ENTRIES),
    .CFG_INDEX (CFG_INDEX)
  ) u_table (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .idle           (state_q == ST_IDLE),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .len_idx        (ent_q[IW-1:0]),
    .start_idx      (ent_d[IW-1:0]),
    .len_m1         (cur_len_s),
    .start          (nxt_start_s),
    .count          (count_s),
    .configured     (configured_s),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_hit        (hit_s)
  );

  // Stream FSM: pointer walk, one-deep strobe pending flag, upload-drop override.
  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    off_d    = off_q;
    pend_d   = pend_q;
    strobe_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (up_rise_s && (ioctl_index == DATA_INDEX) && configured_s) state_d = ST_PAUSE;
        else                                                          state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        pend_d = pend_q | ioctl_rd;
        if (paused) begin
          state_d = ST_FETCH;
          ent_d   = {CW{1'b0}};
          off_d   = 8'd0;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_FETCH: begin
        pend_d  = pend_q | ioctl_rd;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pend_d  = pend_q | ioctl_rd;
        state_d = ST_READY;
      end
      ST_READY: begin
        strobe_s = ioctl_rd | pend_q;
        pend_d   = 1'b0;
        if (strobe_s) begin
          if (off_q == cur_len_s) begin
            off_d = 8'd0;
            ent_d = ent_q + CW'(1'b1);
          end else begin
            off_d = off_q + 8'd1;
            ent_d = ent_q;
          end
          if (ent_d == count_s) state_d = ST_DONE;
          else                  state_d = ST_FETCH;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_DONE: begin
        pend_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_RELEASE: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (up_fall_s && (state_q != ST_IDLE) && (state_q != ST_RELEASE)) state_d = ST_RELEASE;
    else                                                              state_d = state_d;
  end

  // Output next-values are derived from the next state so every output is a flop.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    pause_d  = holds_pause(state_d);
    ram_rd_d = (state_d == ST_FETCH);
    if (state_d == ST_FETCH) ram_addr_d = nxt_start_s + AW'(off_d);
    else                     ram_addr_d = ram_addr_q;
    case (state_d)
      ST_IDLE, ST_DONE, ST_RELEASE: din_d = IDLE_BYTE;
      default: begin
        if (state_q == ST_WAIT) din_d = ram_dout;
        else                    din_d = din_q;
      end
    endcase
  end

  // Main state and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ent_q      <= {CW{1'b0}};
      off_q      <= 8'd0;
      pend_q     <= 1'b0;
      up_prev_q  <= 1'b0;
      din_q      <= IDLE_BYTE;
      ram_addr_q <= {AW{1'b0}};
      ram_rd_q   <= 1'b0;
      pause_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ent_q      <= ent_d;
      off_q      <= off_d;
      pend_q     <= pend_d;
      up_prev_q  <= ioctl_upload;
      din_q      <= din_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      pause_q    <= pause_d;
      busy_q     <= busy_d;
    end
  end

  assign ioctl_din  = din_q;
  assign pause_req  = pause_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign busy       = busy_q;
  assign configured = configured_s;

`ifdef HS_DIRTY_REQ_EN
  logic dirty_q, dirty_d;
  logic up_req_q, up_req_d;

  // A region hit outranks the RELEASE clear so a write racing the upload end is kept.
  always_comb begin
    if (hit_s)                       dirty_d = 1'b1;
    else if (state_q == ST_RELEASE)  dirty_d = 1'b0;
    else                             dirty_d = dirty_q;
    up_req_d = dirty_q & configured_s & ~busy_q;
  end

  // Dirty tracking registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty_q  <= 1'b0;
      up_req_q <= 1'b0;
    end else begin
      dirty_q  <= dirty_d;
      up_req_q <= up_req_d;
    end
  end

  assign ioctl_upload_req = up_req_q;
`else
  logic unused_hit_s;
  assign unused_hit_s     = hit_s;
  assign ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_hiscore_dumper.sv
// Directed, table-driven bench for hiscore_dumper with a 1-cycle-latency RAM returning a[7:0].
module tb_hiscore_dumper;
  localparam int AW = 11;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [7:0]    ioctl_din;
  logic          ioctl_upload_req;
  logic          pause_req;
  logic          paused = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_dout = 8'd0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = 11'd0;
  logic          configured;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       strobe;
    logic [7:0] exp_din;
    logic       exp_pause;
    logic       exp_busy;
  } vec_t;
  vec_t vecs [9];

  hiscore_dumper #(.AW(AW), .ENTRIES(4), .CFG_INDEX(8'd3), .DATA_INDEX(8'd4)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ioctl_download   (ioctl_download),
    .ioctl_wr         (ioctl_wr),
    .ioctl_addr       (ioctl_addr),
    .ioctl_dout       (ioctl_dout),
    .ioctl_index      (ioctl_index),
    .ioctl_upload     (ioctl_upload),
    .ioctl_rd         (ioctl_rd),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .pause_req        (pause_req),
    .paused           (paused),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_dout         (ram_dout),
    .cpu_wr           (cpu_wr),
    .cpu_addr         (cpu_addr),
    .configured       (configured),
    .busy             (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_rd) ram_dout <= ram_addr[7:0];
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic load_table();
    ioctl_index    = 8'd3;
    ioctl_download = 1'b1;
    tick();
    cfg_write(25'd0, 8'h01); cfg_write(25'd1, 8'h00); cfg_write(25'd2, 8'h03); cfg_write(25'd3, 8'h00);
    cfg_write(25'd4, 8'h07); cfg_write(25'd5, 8'hFE); cfg_write(25'd6, 8'h02); cfg_write(25'd7, 8'h00);
    cfg_write(25'd16, 8'h05);
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic strobe();
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
  endtask

  task automatic start_upload();
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    tick();
  endtask

  task automatic end_upload();
    ioctl_upload = 1'b0;
    paused       = 1'b0;
    tick();
    tick();
  endtask

  task automatic play_vectors(input string tag);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].strobe) strobe();
      else                tick();
      tick();
      tick();
      tick();
      check($sformatf("%s din[%0d]", tag, i), {24'd0, ioctl_din}, {24'd0, vecs[i].exp_din});
      check($sformatf("%s pause[%0d]", tag, i), {31'd0, pause_req}, {31'd0, vecs[i].exp_pause});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h02, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'hFE, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'hFF, 1'b1, 1'b1};

    #23 reset_n = 1'b1;
    tick();
    check("rst din", {24'd0, ioctl_din}, 32'hFF);
    check("rst pause", {31'd0, pause_req}, 32'd0);
    check("rst ram_rd", {31'd0, ram_rd}, 32'd0);
    check("rst ram_addr", {21'd0, ram_addr}, 32'd0);
    check("rst configured", {31'd0, configured}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst upreq", {31'd0, ioctl_upload_req}, 32'd0);

    // Main stream with the wrap to address 0.
    load_table();
    check("load configured", {31'd0, configured}, 32'd1);
    start_upload();
    check("up1 pause", {31'd0, pause_req}, 32'd1);
    check("up1 ram_rd idle", {31'd0, ram_rd}, 32'd0);
    paused = 1'b1;
    play_vectors("up1");
    end_upload();
    check("up1 rel busy", {31'd0, busy}, 32'd0);
    check("up1 rel pause", {31'd0, pause_req}, 32'd0);
    check("up1 rel din", {24'd0, ioctl_din}, 32'hFF);

    // Delayed pause ack, with a table download attempted while busy.
    start_upload();
    check("up2 pause", {31'd0, pause_req}, 32'd1);
    ioctl_index    = 8'd3;
    ioctl_download = 1'b1;
    tick();
    cfg_write(25'd1, 8'h40);
    ioctl_download = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("up2 wait ram_rd", {31'd0, ram_rd}, 32'd0);
      check("up2 wait din", {24'd0, ioctl_din}, 32'hFF);
    end
    paused = 1'b1;
    tick();
    check("up2 ram_rd", {31'd0, ram_rd}, 32'd1);
    check("up2 ram_addr", {21'd0, ram_addr}, 32'h100);
    tick();
    check("up2 ram_rd pulse", {31'd0, ram_rd}, 32'd0);
    tick();
    check("up2 byte0", {24'd0, ioctl_din}, 32'h00);

    // Strobe landing in WAIT is held pending and serviced on READY entry.
    strobe();
    tick();
    strobe();
    check("pend byte1", {24'd0, ioctl_din}, 32'h01);
    tick(); tick(); tick();
    check("pend byte2", {24'd0, ioctl_din}, 32'h02);
    strobe(); tick(); tick(); tick();
    check("pend byte3", {24'd0, ioctl_din}, 32'h03);
    strobe(); tick(); tick(); tick();
    check("pend byte4", {24'd0, ioctl_din}, 32'hFE);
    check("pend addr4", {21'd0, ram_addr}, 32'h7FE);
    end_upload();

    // Reset in READY, then an unconfigured upload must be ignored.
    start_upload();
    paused = 1'b1;
    tick(); tick(); tick();
    check("rr ready din", {24'd0, ioctl_din}, 32'h00);
    reset_n = 1'b0;
    #1;
    check("rr din", {24'd0, ioctl_din}, 32'hFF);
    check("rr pause", {31'd0, pause_req}, 32'd0);
    check("rr ram_addr", {21'd0, ram_addr}, 32'd0);
    check("rr busy", {31'd0, busy}, 32'd0);
    check("rr configured", {31'd0, configured}, 32'd0);
    ioctl_upload = 1'b0;
    paused       = 1'b0;
    #3 reset_n = 1'b1;
    tick();
    tick();
    start_upload();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("nocfg pause", {31'd0, pause_req}, 32'd0);
      check("nocfg din", {24'd0, ioctl_din}, 32'hFF);
      check("nocfg busy", {31'd0, busy}, 32'd0);
    end
    end_upload();

    load_table();
    check("reload configured", {31'd0, configured}, 32'd1);

    // CPU writes: outside every region, then inside entry 0.
    cpu_addr = 11'h104;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    tick();
    tick();
    check("miss upreq", {31'd0, ioctl_upload_req}, 32'd0);
    cpu_addr = 11'h102;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    tick();
`ifdef HS_DIRTY_REQ_EN
    check("hit upreq", {31'd0, ioctl_upload_req}, 32'd1);
    start_upload();
    tick();
    check("busy upreq", {31'd0, ioctl_upload_req}, 32'd0);
    paused = 1'b1;
    play_vectors("up3");
    end_upload();
    tick();
    check("rel upreq", {31'd0, ioctl_upload_req}, 32'd0);
`else
    check("nodirty upreq", {31'd0, ioctl_upload_req}, 32'd0);
    start_upload();
    check("up3 pause", {31'd0, pause_req}, 32'd1);
    end_upload();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
